// File: rtl/display_scan.sv
// rtl/display_scan.sv - time-multiplexed hex digit scanner feeding a 7-segment decoder
// Registered outputs, one digit per DIV-cycle dwell, first GUARD cycles dark.
module display_scan #(
   parameter int DIGITS = 4,
   parameter int DIV    = 50000,
   parameter int GUARD  = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   valor,
   input  logic                  blank_lz,
   output logic [3:0]            digito,
   output logic [DIGITS-1:0]     anodo,
   output logic                  blank
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
   localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

   logic [4*DIGITS-1:0] shadow_q, shadow_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [3:0]          digito_q, digito_d;
   logic [DIGITS-1:0]   anodo_q, anodo_d;
   logic                blank_q, blank_d;

   logic                guard;
   logic                lz;
   logic                upper_zero;
   logic [DIGITS-1:0]   anode_sel;

   always_comb begin
      shadow_d = load ? valor : shadow_q;
      cnt_d    = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
      idx_d    = idx_q;
      if (cnt_q == CNT_MAX) begin
         idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
      end
   end

   // Walk from the top nibble down so upper_zero covers positions i..DIGITS-1.
   always_comb begin
      digito_d   = 4'h0;
      anode_sel  = '1;
      upper_zero = 1'b1;
      lz         = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         upper_zero = upper_zero & (shadow_q[4*i +: 4] == 4'h0);
         if (idx_q == IW'(i)) begin
            digito_d     = shadow_q[4*i +: 4];
            anode_sel[i] = 1'b0;
            if (i != 0) begin
               lz = blank_lz & upper_zero;
            end
         end
      end
      guard   = (32'(cnt_q) < 32'(GUARD));
      blank_d = guard | lz;
      anodo_d = blank_d ? '1 : anode_sel;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         shadow_q <= '0;
         cnt_q    <= '0;
         idx_q    <= '0;
         digito_q <= 4'h0;
         anodo_q  <= '1;
         blank_q  <= 1'b1;
      end else begin
         shadow_q <= shadow_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         digito_q <= digito_d;
         anodo_q  <= anodo_d;
         blank_q  <= blank_d;
      end
   end

   assign digito = digito_q;
   assign anodo  = anodo_q;
   assign blank  = blank_q;

endmodule

// File: tb/tb_display_scan.sv
// tb/tb_display_scan.sv - scoreboard bench for display_scan (DIGITS=4, DIV=4, GUARD=1)
// Expected outputs are pushed per driven cycle from a behavioural model and popped after the edge.
module tb_display_scan;

   localparam int DIGITS = 4;
   localparam int DIV    = 4;
   localparam int GUARD  = 1;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        load = 1'b0;
   logic [15:0] valor = 16'h0000;
   logic        blank_lz = 1'b0;
   logic [3:0]  digito;
   logic [3:0]  anodo;
   logic        blank;

   int checks = 0;
   int errors = 0;

   logic [15:0] m_shadow = 16'h0000;
   int          m_cnt = 0;
   int          m_idx = 0;
   logic [8:0]  sb_q[$];

   display_scan #(.DIGITS(DIGITS), .DIV(DIV), .GUARD(GUARD)) dut (
      .clock(clock), .reset(reset), .load(load), .valor(valor),
      .blank_lz(blank_lz), .digito(digito), .anodo(anodo), .blank(blank)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, predict the registered outputs, clock, compare.
   task automatic step(input logic r, input logic ld, input logic [15:0] v, input logic bl);
      logic [3:0] e_dig;
      logic [3:0] e_an;
      logic       e_bl;
      logic       e_lz;
      logic [8:0] item;
      reset = r; load = ld; valor = v; blank_lz = bl;
      if (r) begin
         e_dig = 4'h0; e_an = 4'b1111; e_bl = 1'b1;
         m_shadow = 16'h0000; m_cnt = 0; m_idx = 0;
      end else begin
         e_dig = 4'((m_shadow >> (4 * m_idx)) & 16'h000F);
         e_lz  = bl && (m_idx > 0) && ((m_shadow >> (4 * m_idx)) == 16'h0000);
         e_bl  = (m_cnt < GUARD) || e_lz;
         e_an  = e_bl ? 4'b1111 : ~(4'b0001 << m_idx);
         if (ld) m_shadow = v;
         if (m_cnt == DIV - 1) begin
            m_cnt = 0;
            m_idx = (m_idx + 1) % DIGITS;
         end else begin
            m_cnt++;
         end
      end
      sb_q.push_back({e_dig, e_an, e_bl});
      @(posedge clock);
      #1;
      if (sb_q.size() == 0) begin
         check("sb_underflow", 8'd0, 8'd1);
      end else begin
         item = sb_q.pop_front();
         check("digito", {4'h0, digito}, {4'h0, item[8:5]});
         check("anodo", {4'h0, anodo}, {4'h0, item[4:1]});
         check("blank", {7'h0, blank}, {7'h0, item[0]});
      end
   endtask

   task automatic run(input int n, input logic bl);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 16'h0000, bl);
   endtask

   initial begin
      logic [3:0] exp_dig[4];
      exp_dig[0] = 4'hF; exp_dig[1] = 4'h2; exp_dig[2] = 4'hA; exp_dig[3] = 4'h1;

      // 1. reset held with load asserted
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b1, 16'hFFFF, 1'b0);
         check("rst_anodo", {4'h0, anodo}, 8'h0F);
         check("rst_blank", {7'h0, blank}, 8'h01);
      end
      run(1, 1'b0);
      check("post_rst_guard", {7'h0, blank}, 8'h01);
      run(3, 1'b0);
      check("post_rst_anodo", {4'h0, anodo}, 8'h0E);
      check("post_rst_digito", {4'h0, digito}, 8'h00);

      // 2. plain scan of 1A2F, then wrap
      step(1'b1, 1'b0, 16'h0000, 1'b0);
      step(1'b0, 1'b1, 16'h1A2F, 1'b0);
      run(3, 1'b0);
      check("scan_d0", {4'h0, digito}, {4'h0, exp_dig[0]});
      check("scan_a0", {4'h0, anodo}, 8'h0E);
      for (int d = 1; d < 4; d++) begin
         run(1, 1'b0);
         check("scan_guard_blank", {7'h0, blank}, 8'h01);
         check("scan_guard_anodo", {4'h0, anodo}, 8'h0F);
         run(3, 1'b0);
         check("scan_dig", {4'h0, digito}, {4'h0, exp_dig[d]});
         check("scan_an", {4'h0, anodo}, {4'h0, ~(4'b0001 << d)});
      end
      run(4, 1'b0);
      check("scan_wrap", {4'h0, digito}, 8'h0F);

      // 3. leading-zero blanking: 0005 then 0000
      step(1'b1, 1'b0, 16'h0000, 1'b1);
      step(1'b0, 1'b1, 16'h0005, 1'b1);
      run(3, 1'b1);
      check("lz5_d0", {4'h0, digito}, 8'h05);
      run(4, 1'b1);
      check("lz5_idx1_blank", {7'h0, blank}, 8'h01);
      check("lz5_idx1_anodo", {4'h0, anodo}, 8'h0F);
      run(8, 1'b1);
      step(1'b1, 1'b0, 16'h0000, 1'b1);
      run(4, 1'b1);
      check("lz0_d0_lit", {4'h0, anodo}, 8'h0E);
      run(12, 1'b1);

      // 4. interior zeros: 0300
      step(1'b1, 1'b0, 16'h0000, 1'b1);
      step(1'b0, 1'b1, 16'h0300, 1'b1);
      run(7, 1'b1);
      check("iz_idx1_lit", {4'h0, anodo}, 8'h0D);
      run(4, 1'b1);
      check("iz_idx2", {4'h0, digito}, 8'h03);
      run(4, 1'b1);
      check("iz_idx3_blank", {7'h0, blank}, 8'h01);
      // blank_lz dropped mid-dwell takes effect on the next output
      run(4, 1'b0);

      // 5. load mid-dwell on idx1
      step(1'b1, 1'b0, 16'h0000, 1'b0);
      step(1'b0, 1'b1, 16'h0000, 1'b0);
      run(4, 1'b0);
      step(1'b0, 1'b1, 16'h00F0, 1'b0);
      check("mid_load_old", {4'h0, digito}, 8'h00);
      run(1, 1'b0);
      check("mid_load_new", {4'h0, digito}, 8'h0F);
      run(1, 1'b0);
      check("mid_load_still_idx1", {4'h0, anodo}, 8'h0D);
      run(1, 1'b0);
      check("mid_load_advance", {7'h0, blank}, 8'h01);
      run(4, 1'b0);

      // 6. reset mid-scan at idx=2 cnt=3 with load high
      step(1'b1, 1'b0, 16'h0000, 1'b0);
      step(1'b0, 1'b1, 16'h4321, 1'b0);
      run(10, 1'b0);
      step(1'b1, 1'b1, 16'hFFFF, 1'b0);
      check("mid_rst_anodo", {4'h0, anodo}, 8'h0F);
      run(1, 1'b0);
      check("mid_rst_resume_blank", {7'h0, blank}, 8'h01);
      run(1, 1'b0);
      check("mid_rst_resume_anodo", {4'h0, anodo}, 8'h0E);
      check("mid_rst_shadow0", {4'h0, digito}, 8'h00);
      run(6, 1'b0);

      check("sb_empty", 8'(sb_q.size()), 8'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/display_scan.md
Name: display_scan

Overview:
- Time-multiplexed scanner that sits directly upstream of the 7-segment decoder.
- Captures a multi-digit hex value on a load strobe and steps through its nibbles one digit at a time.
- Presents the current nibble to the decoder input and drives active-low digit anodes.
- Supports optional leading-zero blanking and an anti-ghosting guard interval at each digit change.

Parameters:
DIGITS, 4, number of digits scanned; data width is 4*DIGITS
DIV, 50000, clock cycles each digit is held (dwell); must be >= 1
GUARD, 2, cycles at the start of each dwell with all anodes off; must satisfy GUARD < DIV

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
load  input  1  capture strobe; shadow register takes valor on the edge where load=1
valor  input  4*DIGITS  value to display; nibble 0 (bits 3:0) is the rightmost digit
blank_lz  input  1  1 = blank leading zeros
digito  output  4  nibble for the current digit; feeds the decoder's 4-bit input
anodo  output  DIGITS  active-low digit enables, one-hot-low when a digit is lit
blank  output  1  1 = current digit is not lit (guard, blanked, or reset)

Behaviour:
- One clock; reset is synchronous and active-high. Reset wins over load and all other inputs.
- State registers:
  - shadow (4*DIGITS bits): reset to 0; loaded from valor when load=1.
  - cnt (0..DIV-1): prescaler, reset to 0. Increments every cycle; wraps DIV-1 -> 0.
  - idx (0..DIGITS-1): reset to 0. Increments on the edge where cnt==DIV-1; wraps DIGITS-1 -> 0.
- Outputs are registered. Each edge computes them from the pre-edge state (shadow, cnt, idx) and the current blank_lz, giving a 1-cycle latency.
- Output reset values: digito=0, anodo=all ones, blank=1.
- Output rules:
  - digito <= shadow[4*idx+3 : 4*idx]. This is always driven, even while blanked.
  - guard = (cnt < GUARD).
  - lz = blank_lz AND idx>0 AND every nibble at positions idx..DIGITS-1 equals 0. Digit 0 is never blanked, so value 0 shows a single "0".
  - blank <= guard OR lz.
  - anodo <= all ones if (guard OR lz); otherwise all ones with bit idx cleared.
- Load mid-scan:
  - The new shadow is visible on the outputs one cycle after the load edge.
  - cnt and idx are not disturbed; the scan never restarts on load.
- load held high: shadow follows valor every cycle.
- Reset mid-scan: the next edge forces cnt=0, idx=0, shadow=0 and the reset output values, regardless of load.
- Scan order: idx 0,1,...,DIGITS-1,0,...; each digit lasts exactly DIV cycles, the first GUARD of which are dark.
- Degenerate settings:
  - DIV=1 with GUARD=0: idx advances every cycle and no guard is inserted.
  - GUARD=0: guard is never active.
- blank_lz may change at any time; the change takes effect on the next registered output.
- The block uses no combinational paths from inputs to outputs.

Test Plan:
(Bench parameters: DIGITS=4, DIV=4, GUARD=1.)
1. Reset: hold reset 3 cycles with load=1 and valor=16'hFFFF -> anodo=4'b1111, blank=1, digito=0 throughout. After release, shadow stays 0 and digito=0 with anodo=4'b1110 from the 2nd dwell cycle.
2. Plain scan: load 16'h1A2F with blank_lz=0 -> digito sequence F,2,A,1, each held 4 cycles. anodo is 1110, 1101, 1011, 0111 on dwell cycles 2–4 and 1111 with blank=1 on dwell cycle 1. The pattern then wraps to F.
3. Leading zeros: blank_lz=1, value 16'h0005 -> idx0: digito=5, anodo=1110; idx1–3: blank=1, anodo=1111. Value 16'h0000 -> idx0 lit showing 0; others blank.
4. Interior zeros: blank_lz=1, value 16'h0300 -> idx0 shows 0 (lit), idx1 shows 0 (lit, higher nibble nonzero), idx2 shows 3, idx3 blanked.
5. Load mid-dwell: shadow 16'h0000, idx=1 on dwell cycle 2; pulse load with 16'h00F0 -> digito becomes F one cycle later. idx advance timing is unchanged (still 2 more cycles on idx1).
6. Reset mid-scan at idx=2, cnt=3, with load=1 on the same edge -> next cycle idx=0, cnt=0, shadow=0, anodo=1111, blank=1. Scan resumes from digit 0.
